// File: rtl/axis_downsizer_arbiter.sv
//==============================================================================
// Module      : axis_downsizer_arbiter
// Description : Round-robin burst scheduler feeding one axis_downsizer.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module axis_downsizer_arbiter #(
    parameter int NUM_PORTS        = 4,
    parameter int AXIS_TDATA_WIDTH = 128,
    parameter int CNTR_WIDTH       = 8,
    localparam int SEL_WIDTH       = $clog2(NUM_PORTS)
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [CNTR_WIDTH-1:0]                 cfg_data,
    input  logic [NUM_PORTS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]                  s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                  s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]           m_axis_tdata,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic [SEL_WIDTH-1:0]                  m_axis_tdest
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [SEL_WIDTH-1:0]  grant_q, grant_d;
    logic [SEL_WIDTH-1:0]  ptr_q,   ptr_d;
    logic [CNTR_WIDTH-1:0] cntr_q,  cntr_d;

    logic                  hit;
    logic [SEL_WIDTH-1:0]  winner;
    logic [SEL_WIDTH-1:0]  cand;
    logic                  handshake;
    logic                  granting;

    // Walk from the highest offset down so the port closest to ptr wins last.
    always_comb begin
        hit    = 1'b0;
        winner = ptr_q;
        cand   = ptr_q;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            cand = SEL_WIDTH'((int'(ptr_q) + i) % NUM_PORTS);
            if (s_axis_tvalid[cand]) begin
                hit    = 1'b1;
                winner = cand;
            end
        end
    end

    assign granting      = aresetn && (state_q == ST_GRANT);
    assign m_axis_tdata  = s_axis_tdata[int'(grant_q)*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
    assign m_axis_tvalid = granting && s_axis_tvalid[grant_q];
    assign m_axis_tdest  = grant_q;
    assign handshake     = m_axis_tvalid && m_axis_tready;

    always_comb begin
        s_axis_tready = '0;
        if (granting) begin
            s_axis_tready[grant_q] = m_axis_tready;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cntr_d  = cntr_q;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    grant_d = winner;
                    cntr_d  = (cfg_data == '0) ? CNTR_WIDTH'(1) : cfg_data;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (handshake) begin
                    cntr_d = cntr_q - CNTR_WIDTH'(1);
                    if (cntr_q == CNTR_WIDTH'(1)) begin
                        state_d = ST_IDLE;
                        ptr_d   = (grant_q == SEL_WIDTH'(NUM_PORTS - 1)) ? '0
                                                                        : grant_q + SEL_WIDTH'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cntr_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cntr_q  <= cntr_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_downsizer_arbiter.sv
//==============================================================================
// Module      : tb_axis_downsizer_arbiter
// Description : Directed self-checking bench for axis_downsizer_arbiter.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_axis_downsizer_arbiter;

    localparam int NP = 4;
    localparam int W  = 128;
    localparam int CW = 8;
    localparam int SW = 2;

    logic            aclk;
    logic            aresetn;
    logic [CW-1:0]   cfg_data;
    logic [NP*W-1:0] s_tdata;
    logic [NP-1:0]   s_tvalid;
    logic [NP-1:0]   s_tready;
    logic [W-1:0]    m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic [SW-1:0]   m_tdest;

    int n_cmp;
    int n_bad;
    int ready_viol;
    int seq [NP];
    int q_log [$];
    logic [W-1:0] q_data [$];
    logic toggle_rdy;

    axis_downsizer_arbiter #(
        .NUM_PORTS(NP), .AXIS_TDATA_WIDTH(W), .CNTR_WIDTH(CW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_data(cfg_data),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tdest(m_tdest)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [W-1:0] make_data(input int k, input int n);
        logic [W-1:0] d;
        d        = '0;
        d[31:24] = 8'(k);
        d[23:0]  = 24'(n);
        return d;
    endfunction

    // One clock per iteration: log tdest of each handshake (-1 for none).
    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            if (toggle_rdy) m_tready = ~m_tready;
            for (int k = 0; k < NP; k++) s_tdata[k*W +: W] = make_data(k, seq[k]);
            #1;
            if (m_tvalid && m_tready) begin
                q_log.push_back(int'(m_tdest));
                q_data.push_back(m_tdata);
                seq[m_tdest] = seq[m_tdest] + 1;
            end else begin
                q_log.push_back(-1);
            end
            if (m_tvalid) begin
                if (((s_tready & ~(NP'(1) << m_tdest)) != '0) || (s_tready[m_tdest] !== m_tready))
                    ready_viol++;
            end else if (s_tready != '0) begin
                ready_viol++;
            end
            @(posedge aclk); #1;
        end
    endtask

    task automatic do_reset();
        aresetn    = 1'b0;
        s_tvalid   = '0;
        toggle_rdy = 1'b0;
        @(posedge aclk); #1;
        aresetn    = 1'b1;
        q_log.delete();
        q_data.delete();
        for (int k = 0; k < NP; k++) seq[k] = 0;
        ready_viol = 0;
    endtask

    task automatic test_reset();
        s_tvalid = '1;
        m_tready = 1'b1;
        cfg_data = 8'd2;
        aresetn  = 1'b0;
        @(posedge aclk); #1;
        n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid: got %0b expected 0", m_tvalid); end
        n_cmp++; if (s_tready !== 4'b0000) begin n_bad++; $display("FAIL reset_tready: got %b expected 0000", s_tready); end
        n_cmp++; if (m_tdest !== 2'd0) begin n_bad++; $display("FAIL reset_tdest: got %0d expected 0", m_tdest); end
        aresetn = 1'b1;
        #1;
        n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL idle_tvalid: got %0b expected 0", m_tvalid); end
        n_cmp++; if (s_tready !== 4'b0000) begin n_bad++; $display("FAIL idle_tready: got %b expected 0000", s_tready); end
        @(posedge aclk); #1;
    endtask

    task automatic test_single_port();
        int exp_log [$];
        do_reset();
        cfg_data = 8'd3; m_tready = 1'b1; s_tvalid = 4'b0100;
        run_cycles(8);
        s_tvalid = '0;
        exp_log = '{-1, 2, 2, 2, -1, 2, 2, 2};
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (q_log[i] !== exp_log[i]) begin n_bad++; $display("FAIL single_log[%0d]: got %0d expected %0d", i, q_log[i], exp_log[i]); end
        end
        n_cmp++; if (q_data.size() !== 6) begin n_bad++; $display("FAIL single_count: got %0d expected 6", q_data.size()); end
        for (int i = 0; i < q_data.size() && i < 6; i++) begin
            n_cmp++;
            if (q_data[i] !== make_data(2, i)) begin n_bad++; $display("FAIL single_data[%0d]: got %h expected %h", i, q_data[i], make_data(2, i)); end
        end
        n_cmp++; if (ready_viol !== 0) begin n_bad++; $display("FAIL single_ready: got %0d violations expected 0", ready_viol); end
    endtask

    task automatic test_all_ports();
        int exp_log [$];
        int cnt [NP];
        do_reset();
        cfg_data = 8'd2; m_tready = 1'b1; s_tvalid = 4'b1111;
        run_cycles(15);
        s_tvalid = '0;
        exp_log = '{-1, 0, 0, -1, 1, 1, -1, 2, 2, -1, 3, 3, -1, 0, 0};
        for (int i = 0; i < 15; i++) begin
            n_cmp++;
            if (q_log[i] !== exp_log[i]) begin n_bad++; $display("FAIL all_log[%0d]: got %0d expected %0d", i, q_log[i], exp_log[i]); end
        end
        for (int k = 0; k < NP; k++) cnt[k] = 0;
        for (int i = 0, j = 0; i < 15; i++) begin
            if (exp_log[i] >= 0 && j < q_data.size()) begin
                n_cmp++;
                if (q_data[j] !== make_data(exp_log[i], cnt[exp_log[i]])) begin
                    n_bad++; $display("FAIL all_data[%0d]: got %h expected %h", j, q_data[j], make_data(exp_log[i], cnt[exp_log[i]]));
                end
                cnt[exp_log[i]]++;
                j++;
            end
        end
    endtask

    task automatic test_wrap();
        int exp_log [$];
        do_reset();
        cfg_data = 8'd1; m_tready = 1'b1; s_tvalid = 4'b0001;
        run_cycles(2);
        s_tvalid = 4'b1001;
        run_cycles(8);
        s_tvalid = '0;
        exp_log = '{-1, 0, -1, 3, -1, 0, -1, 3, -1, 0};
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (q_log[i] !== exp_log[i]) begin n_bad++; $display("FAIL wrap_log[%0d]: got %0d expected %0d", i, q_log[i], exp_log[i]); end
        end
    endtask

    task automatic test_cfg();
        int exp_log [$];
        do_reset();
        cfg_data = 8'd0; m_tready = 1'b1; s_tvalid = 4'b1111;
        run_cycles(6);
        exp_log = '{-1, 0, -1, 1, -1, 2};
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (q_log[i] !== exp_log[i]) begin n_bad++; $display("FAIL cfg0_log[%0d]: got %0d expected %0d", i, q_log[i], exp_log[i]); end
        end
        do_reset();
        cfg_data = 8'd4; s_tvalid = 4'b0001;
        run_cycles(2);
        cfg_data = 8'd1;
        run_cycles(6);
        s_tvalid = '0;
        exp_log = '{-1, 0, 0, 0, 0, -1, 0, -1};
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (q_log[i] !== exp_log[i]) begin n_bad++; $display("FAIL cfgchg_log[%0d]: got %0d expected %0d", i, q_log[i], exp_log[i]); end
        end
    endtask

    task automatic test_backpressure();
        int hs;
        do_reset();
        cfg_data = 8'd4; m_tready = 1'b0; toggle_rdy = 1'b1; s_tvalid = 4'b0110;
        run_cycles(10);
        toggle_rdy = 1'b0; s_tvalid = '0; m_tready = 1'b1;
        hs = 0;
        for (int i = 0; i < 10; i++) begin
            if (q_log[i] >= 0) begin
                n_cmp++;
                if (q_log[i] !== 1) begin n_bad++; $display("FAIL bp_dest[%0d]: got %0d expected 1", i, q_log[i]); end
                if (hs < q_data.size()) begin
                    n_cmp++;
                    if (q_data[hs] !== make_data(1, hs)) begin n_bad++; $display("FAIL bp_data[%0d]: got %h expected %h", hs, q_data[hs], make_data(1, hs)); end
                end
                hs++;
            end
        end
        n_cmp++; if (hs !== 4) begin n_bad++; $display("FAIL bp_handshakes: got %0d expected 4", hs); end
        n_cmp++; if (ready_viol !== 0) begin n_bad++; $display("FAIL bp_ready: got %0d violations expected 0", ready_viol); end
    endtask

    task automatic test_reset_mid_burst();
        int exp_log [$];
        do_reset();
        cfg_data = 8'd1; m_tready = 1'b1; s_tvalid = 4'b0001;
        run_cycles(2);
        cfg_data = 8'd4; s_tvalid = 4'b0100;
        run_cycles(3);
        aresetn = 1'b0;
        #1;
        n_cmp++; if (s_tready !== 4'b0000) begin n_bad++; $display("FAIL midrst_tready: got %b expected 0000", s_tready); end
        n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL midrst_tvalid: got %0b expected 0", m_tvalid); end
        @(posedge aclk); #1;
        aresetn  = 1'b1;
        s_tvalid = 4'b0011;
        run_cycles(2);
        s_tvalid = '0;
        exp_log = '{-1, 0, -1, 2, 2, -1, 0};
        for (int i = 0; i < 7; i++) begin
            n_cmp++;
            if (q_log[i] !== exp_log[i]) begin n_bad++; $display("FAIL midrst_log[%0d]: got %0d expected %0d", i, q_log[i], exp_log[i]); end
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; ready_viol = 0; toggle_rdy = 1'b0;
        aresetn = 1'b0; cfg_data = '0; s_tdata = '0; s_tvalid = '0; m_tready = 1'b0;
        for (int k = 0; k < NP; k++) seq[k] = 0;
        test_reset();
        test_single_port();
        test_all_ports();
        test_wrap();
        test_cfg();
        test_backpressure();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
